// File: rtl/fv_enc_pkg.sv
// Shared types and helpers for the negacyclic polynomial multiplier:
// FSM state encoding, the negacyclic index fold and the lane/size sanity check.
package fv_enc_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    COMP  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Target coefficient of a[i]*b[j] in Z[x]/(x^n+1): wrap=1 means the term
  // folded past x^n and must be subtracted.
  function automatic int neg_idx(input int i, input int j, input int n, output logic wrap);
    wrap = ((i + j) >= n);
    return (i + j) % n;
  endfunction

  function automatic bit cfg_ok(input int n, input int p);
    return (n >= 2) && ((n & (n - 1)) == 0) && (p > 0) && ((n % p) == 0);
  endfunction

endpackage

// File: rtl/negacyclic_poly_mul_if.sv
// Coefficient input stream and product output stream of negacyclic_poly_mul.
interface negacyclic_poly_mul_if #(
  parameter int QW = 64,
  parameter int UW = 1
) ();
  // A beat transfers on the rising clock edge where valid && ready are both
  // high; a source holds its payload stable and never drops valid until then.
  logic          s_valid;
  logic          s_ready;
  logic [QW-1:0] s_a;
  logic [UW-1:0] s_b;
  logic          m_valid;
  logic          m_ready;
  logic [QW-1:0] m_data;
  logic          m_last;

  modport slave (
    input  s_valid, s_a, s_b, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_a, s_b, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/poly_mac_lane.sv
// One multiply-accumulate lane: acc_out = acc_in +/- a_i*ext(b_j) mod 2^QW.
// NEGACYCLIC_POLY_MUL_SIGNED_B_EN selects sign extension of b_j (default zero).
module poly_mac_lane #(
  parameter int QW = 64,
  parameter int UW = 1
) (
  input  logic [QW-1:0] a_i,
  input  logic [UW-1:0] b_j,
  input  logic [QW-1:0] acc_in,
  input  logic          wrap,
  output logic [QW-1:0] acc_out
);
  logic [QW-1:0] b_ext;
  logic [QW-1:0] prod;

`ifdef NEGACYCLIC_POLY_MUL_SIGNED_B_EN
  assign b_ext = QW'($signed(b_j));
`else
  assign b_ext = QW'(b_j);
`endif

  assign prod    = a_i * b_ext;
  assign acc_out = wrap ? (acc_in - prod) : (acc_in + prod);
endmodule

// File: rtl/negacyclic_poly_mul.sv
// c = a*b mod (x^N + 1) mod 2^QW with P parallel MAC lanes, streamed in and out.
// NEGACYCLIC_POLY_MUL_SIGNED_B_EN makes b coefficients two's complement.
module negacyclic_poly_mul
  import fv_enc_pkg::*;
#(
  parameter int N  = 16,
  parameter int QW = 64,
  parameter int UW = 1,
  parameter int P  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  negacyclic_poly_mul_if.slave   sif,
  output logic                   busy,
  output state_t                 dbg_state
);
  localparam int G  = N / P;
  localparam int IW = $clog2(N);
  localparam int GW = (G > 1) ? $clog2(G) : 1;

  if (!cfg_ok(N, P)) begin : g_bad_cfg
    $error("negacyclic_poly_mul: N must be a power of two >= 2 and divisible by P");
  end

  state_t        state;
  logic [IW-1:0] ld_idx;
  logic [IW-1:0] out_idx;
  logic [IW-1:0] j;
  logic [GW-1:0] grp;
  logic [QW-1:0] a_mem [N];
  logic [UW-1:0] b_mem [N];
  logic [QW-1:0] acc   [N];

  logic [IW-1:0] lane_ai  [P];
  logic [IW-1:0] lane_idx [P];
  logic          lane_wrap[P];
  logic [QW-1:0] lane_out [P];

  // Lane l of a step handles a[grp*P+l]*b[j]; the P targets are distinct.
  always_comb begin
    for (int l = 0; l < P; l++) begin
      lane_ai[l]  = IW'(int'(grp) * P + l);
      lane_idx[l] = IW'(neg_idx(int'(grp) * P + l, int'(j), N, lane_wrap[l]));
    end
  end

  for (genvar g = 0; g < P; g++) begin : g_lane
    poly_mac_lane #(.QW(QW), .UW(UW)) u_lane (
      .a_i     (a_mem[lane_ai[g]]),
      .b_j     (b_mem[j]),
      .acc_in  (acc[lane_idx[g]]),
      .wrap    (lane_wrap[g]),
      .acc_out (lane_out[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LOAD;
      ld_idx  <= '0;
      out_idx <= '0;
      j       <= '0;
      grp     <= '0;
      for (int k = 0; k < N; k++) begin
        a_mem[k] <= '0;
        b_mem[k] <= '0;
        acc[k]   <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (sif.s_valid) begin
            a_mem[ld_idx] <= sif.s_a;
            b_mem[ld_idx] <= sif.s_b;
            ld_idx        <= ld_idx + IW'(1);
            if (ld_idx == IW'(N - 1)) begin
              state <= COMP;
              j     <= '0;
              grp   <= '0;
            end
          end
        end
        COMP: begin
          for (int l = 0; l < P; l++) begin
            acc[lane_idx[l]] <= lane_out[l];
          end
          if (grp == GW'(G - 1)) begin
            grp <= '0;
            if (j == IW'(N - 1)) begin
              j       <= '0;
              out_idx <= '0;
              state   <= DRAIN;
            end else begin
              j <= j + IW'(1);
            end
          end else begin
            grp <= grp + GW'(1);
          end
        end
        DRAIN: begin
          if (sif.m_ready) begin
            if (out_idx == IW'(N - 1)) begin
              // Clear the accumulators so the next product starts from zero.
              for (int k = 0; k < N; k++) begin
                acc[k] <= '0;
              end
              out_idx <= '0;
              ld_idx  <= '0;
              state   <= LOAD;
            end else begin
              out_idx <= out_idx + IW'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign sif.s_ready = (state == LOAD);
  assign sif.m_valid = (state == DRAIN);
  assign sif.m_data  = (state == DRAIN) ? acc[out_idx] : '0;
  assign sif.m_last  = (state == DRAIN) && (out_idx == IW'(N - 1));
  assign busy        = (state != LOAD);
  assign dbg_state   = state;
endmodule

// File: tb/tb_negacyclic_poly_mul.sv
// Bench for negacyclic_poly_mul: directed and random products checked against
// a full-product-then-fold model of multiplication in Z[x]/(x^N+1).
module tb_negacyclic_poly_mul;
  import fv_enc_pkg::*;

  localparam int N  = 16;
  localparam int QW = 64;
  localparam int P  = 4;
`ifdef NEGACYCLIC_POLY_MUL_SIGNED_B_EN
  localparam int UW = 2;
`else
  localparam int UW = 1;
`endif
  localparam int COMP_CYC = N * N / P;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   busy;
  state_t dbg_state;

  always #5 clk = ~clk;

  negacyclic_poly_mul_if #(.QW(QW), .UW(UW)) dif ();

  negacyclic_poly_mul #(.N(N), .QW(QW), .UW(UW), .P(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .sif       (dif),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int            vectors     = 0;
  int            miscompares = 0;
  logic [QW-1:0] exp_q[$];
  bit   [QW-1:0] va [N];
  bit   [UW-1:0] vb [N];

  task automatic chk(input string tag, input logic [QW-1:0] obs, input logic [QW-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain 2N-1 term product, then fold x^(k+N) = -x^k.
  task automatic build_expected();
    bit [QW-1:0] p [2*N];
    bit [QW-1:0] bx;
    foreach (p[k]) p[k] = '0;
    for (int i = 0; i < N; i++) begin
      for (int jj = 0; jj < N; jj++) begin
`ifdef NEGACYCLIC_POLY_MUL_SIGNED_B_EN
        bx = QW'($signed(vb[jj]));
`else
        bx = QW'(vb[jj]);
`endif
        p[i+jj] = p[i+jj] + va[i] * bx;
      end
    end
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back(p[k] - p[k+N]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_a_ramp();
    for (int k = 0; k < N; k++) va[k] = QW'(k + 1);
  endtask

  task automatic set_b_mono(input int deg);
    for (int k = 0; k < N; k++) vb[k] = '0;
    vb[deg] = UW'(1);
  endtask

  task automatic load_poly(input bit gaps);
    int g;
    for (int k = 0; k < N; k++) begin
      if (gaps) begin
        dif.s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      dif.s_valid = 1'b1;
      dif.s_a     = va[k];
      dif.s_b     = vb[k];
      g = 0;
      while (!dif.s_ready && g < 200) begin @(posedge clk); #1; g++; end
      chk("s_ready_at_load", QW'(dif.s_ready), 1);
      @(posedge clk); #1;
    end
    dif.s_valid = 1'b0;
    dif.s_a     = '0;
    dif.s_b     = '0;
    chk("busy_after_load", QW'(busy), 1);
    chk("s_ready_after_load", QW'(dif.s_ready), 0);
  endtask

  // Called right after the final input handshake; e counts edges since then,
  // so the handshake cycle itself makes the latency e+1.
  task automatic drain_check(input string tag, input bit bp, input bit chk_lat);
    int            e       = 0;
    int            k       = 0;
    bit            seen    = 1'b0;
    bit            holding = 1'b0;
    logic [QW-1:0] held_d  = '0;
    logic          held_l  = 1'b0;
    logic [QW-1:0] ex;
    build_expected();
    while (exp_q.size() > 0 && e < 2000) begin
      dif.m_ready = bp ? ((e % 2) == 0) : 1'b1;
      if (dif.m_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (chk_lat) chk({tag, "_latency"}, QW'(e + 1), QW'(COMP_CYC + 1));
        end
        chk({tag, "_busy"}, QW'(busy), 1);
        if (holding) begin
          chk({tag, "_hold_data"}, dif.m_data, held_d);
          chk({tag, "_hold_last"}, QW'(dif.m_last), QW'(held_l));
        end
        if (dif.m_ready) begin
          ex = exp_q.pop_front();
          chk($sformatf("%s_c%0d", tag, k), dif.m_data, ex);
          chk($sformatf("%s_last%0d", tag, k), QW'(dif.m_last), QW'(k == N - 1));
          k++;
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          held_d  = dif.m_data;
          held_l  = dif.m_last;
        end
      end
      @(posedge clk); #1;
      e++;
    end
    chk({tag, "_all_drained"}, QW'(exp_q.size()), 0);
    chk({tag, "_s_ready_next"}, QW'(dif.s_ready), 1);
    chk({tag, "_busy_cleared"}, QW'(busy), 0);
    chk({tag, "_m_valid_low"}, QW'(dif.m_valid), 0);
    dif.m_ready = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    dif.s_valid = 1'b0;
    dif.s_a     = '0;
    dif.s_b     = '0;
    dif.m_ready = 1'b0;
    #12;
    chk("rst_s_ready", QW'(dif.s_ready), 1);
    chk("rst_m_valid", QW'(dif.m_valid), 0);
    chk("rst_m_data",  dif.m_data, 0);
    chk("rst_m_last",  QW'(dif.m_last), 0);
    chk("rst_busy",    QW'(busy), 0);
    chk("rst_state",   QW'(dbg_state), QW'(LOAD));
    @(posedge clk); #1;
    rst = 1'b0;
    dif.m_ready = 1'b1;

    // identity b = x^0, with first-output latency
    set_a_ramp(); set_b_mono(0);
    load_poly(1'b0);
    drain_check("ident", 1'b0, 1'b1);

    // negacyclic shift b = x^1
    set_a_ramp(); set_b_mono(1);
    load_poly(1'b0);
    drain_check("shift", 1'b0, 1'b1);

    // all-ones full product
    for (int k = 0; k < N; k++) begin va[k] = 1; vb[k] = UW'(1); end
    load_poly(1'b0);
    drain_check("ones", 1'b0, 1'b0);

    // back-pressure on output, gapped input
    set_a_ramp(); set_b_mono(0);
    load_poly(1'b1);
    drain_check("bp_ident", 1'b1, 1'b0);

    // reset in the middle of COMP, then a clean identity run
    set_a_ramp(); set_b_mono(3);
    load_poly(1'b0);
    repeat (20) begin @(posedge clk); #1; end
    chk("mid_state_comp", QW'(dbg_state), QW'(COMP));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_s_ready", QW'(dif.s_ready), 1);
    chk("mid_rst_m_valid", QW'(dif.m_valid), 0);
    chk("mid_rst_busy",    QW'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_a_ramp(); set_b_mono(0);
    load_poly(1'b0);
    drain_check("post_rst_ident", 1'b0, 1'b1);

    // all-ones a with b = 1 wraps to 2^QW-1
    for (int k = 0; k < N; k++) va[k] = '1;
    set_b_mono(0);
    load_poly(1'b0);
    drain_check("wrap_max", 1'b0, 1'b0);

`ifdef NEGACYCLIC_POLY_MUL_SIGNED_B_EN
    // b_0 = -1 negates a
    set_a_ramp();
    for (int k = 0; k < N; k++) vb[k] = '0;
    vb[0] = '1;
    load_poly(1'b0);
    drain_check("signed_neg", 1'b0, 1'b0);
`endif

    // random operands, random gaps and back-pressure
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) begin
        va[k] = {$urandom(), $urandom()};
        vb[k] = UW'($urandom_range(0, (1 << UW) - 1));
      end
      load_poly(r[0]);
      drain_check($sformatf("rand%0d", r), r[1], 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/negacyclic_poly_mul.md
Name: negacyclic_poly_mul

Overview:
- Parametrised successor to the FV-encryption polynomial multiplier top.
- Computes c = a·b mod (x^N + 1) mod 2^QW, where a holds N coefficients of QW bits (ciphertext/key side) and b holds N small coefficients of UW bits (u/e-style polynomial).
- Generalised with P parallel MAC lanes, streaming valid/ready input and output, and back-pressure.
- Sits between the coefficient source and the FV encryption datapath; one polynomial product per operation.

Parameters:
- N, 16, polynomial length; power of two, ≥ 2.
- QW, 64, coefficient bit-width of a and c; modulus is 2^QW (natural wrap).
- UW, 1, bit-width of b coefficients.
- P, 4, parallel MAC lanes; must divide N (elaboration error otherwise).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- s_valid  in  1  input coefficient pair valid.
- s_ready  out  1  block accepts input (LOAD state).
- s_a  in  QW  coefficient a_k, k ascending from 0.
- s_b  in  UW  coefficient b_k, same index as s_a.
- m_valid  out  1  output coefficient valid.
- m_ready  in  1  downstream accepts output.
- m_data  out  QW  coefficient c_k, k ascending from 0.
- m_last  out  1  high with c_{N-1}.
- busy  out  1  high in COMP or DRAIN.

Behaviour:
- Reset (async, any state):
  - state=LOAD; all counters 0; a/b/acc arrays 0.
  - s_ready=1 once state=LOAD; m_valid=0, m_data=0, m_last=0, busy=0.
- Outputs: s_ready=(state==LOAD); busy=!s_ready; m_valid=(state==DRAIN); m_data=acc[out_idx] in DRAIN, else 0; m_last=m_valid && out_idx==N-1.
- LOAD:
  - Each s_valid&&s_ready stores a[ld_idx]=s_a and b[ld_idx]=s_b, then ld_idx++.
  - On the handshake at ld_idx==N-1: go to COMP, with j=0 and grp=0.
- COMP:
  - One step per cycle. Step(j,grp): for lane l, i=grp·P+l, idx=(i+j) mod N, t=a[i]·b[j] truncated to QW.
  - acc[idx] += t if i+j<N; else acc[idx] −= t (mod 2^QW).
  - The P target indices in a step are distinct, so there are no write conflicts.
  - grp increments; when it wraps at N/P−1, j increments.
  - After step (N−1, N/P−1): go to DRAIN with out_idx=0.
  - Exactly N·N/P cycles in COMP (64 at defaults).
  - s_valid is ignored in COMP and DRAIN.
- DRAIN:
  - On m_valid&&m_ready: out_idx++.
  - On the handshake with m_last: clear acc to 0, ld_idx=0, go to LOAD.
  - While m_ready=0, m_data and m_last are held stable.
- Latency: last input handshake to first m_valid = N·N/P + 1 cycles.
- Back-to-back operation: s_ready rises in the cycle after the final output handshake.
- Arithmetic: b[j] is zero-extended to QW (unsigned) unless the optional feature is enabled. All sums wrap mod 2^QW; no saturation and no overflow flag.

Optional Feature:
- Macro: NEGACYCLIC_POLY_MUL_SIGNED_B_EN.
- Defined: b coefficients are two's complement, sign-extended to QW before multiply (e.g. UW=2 gives ternary {−1,0,1}).
- Undefined: b is unsigned and zero-extended.
- Only the extension logic differs; ports and timing are identical.

Decomposition:
- Shared package fv_enc_pkg holds:
  - the state enum typedef (LOAD, COMP, DRAIN);
  - a localparam-style function for idx=(i+j) mod N with its wrap flag;
  - the elaboration check N%P==0.
- Sub-module poly_mac_lane (combinational, instantiated P times):
  - inputs a_i, b_j, acc_in, wrap;
  - output acc_out = acc_in ± a_i·ext(b_j) mod 2^QW.
  - The top owns the FSM, counters and storage.

Test Plan:
- Identity: a_k=k+1, b=x^0 (b_0=1, else 0), m_ready=1 → c_k=k+1 for all k, m_last at c_15, first m_valid 65 cycles after last input.
- Negacyclic shift: a_k=k+1, b=x^1 → c_0=2^64−16, c_k=k for k=1..15.
- Full product: a_k=1, b_k=1 for all k → c_k=2k+2−16 mod 2^64, so c_0=2^64−14, c_7=0, c_15=16.
- Back-pressure: identity test with m_ready toggled 1/0 every cycle and s_valid randomly gapped → identical c sequence, m_data stable while m_ready=0, busy high until final handshake.
- Reset mid-COMP: assert rst 20 cycles into COMP → s_ready=1 and m_valid=0 immediately; a fresh identity run then yields exact c_k=k+1 with no residue.
- Wrap/signed:
  - a_k=2^64−1, b_0=1 → c_k=2^64−1.
  - With NEGACYCLIC_POLY_MUL_SIGNED_B_EN, UW=2, b_0=2'b11, a_k=k+1 → c_k=2^64−(k+1).
